// File: rtl/ppwm_multi_pkg.sv
// Shared types and default sizing for the multi-channel PWM block.
package ppwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  localparam int PWM_NUM_CH_DEF = 4;
  localparam int PWM_CW_DEF     = 10;

endpackage

// File: rtl/ppwm_multi_if.sv
// Control/status bundle between the PWM block and its host.
interface ppwm_multi_if
  import ppwm_pkg::*;
#(
  parameter int NUM_CH = PWM_NUM_CH_DEF,
  parameter int CW     = PWM_CW_DEF
);

  logic                   en_i;
  logic                   mode_i;
  logic [CW-1:0]          period_i;
  logic [NUM_CH*CW-1:0]   cmp_i;
  logic [NUM_CH-1:0]      pol_i;
  logic                   upd_req_i;
  logic                   upd_pending_o;
  logic                   period_start_o;
  logic [NUM_CH-1:0]      pwm_o;

  modport master (
    output en_i, mode_i, period_i, cmp_i, pol_i, upd_req_i,
    input  upd_pending_o, period_start_o, pwm_o
  );

  modport slave (
    input  en_i, mode_i, period_i, cmp_i, pol_i, upd_req_i,
    output upd_pending_o, period_start_o, pwm_o
  );

endinterface

// File: rtl/ppwm_multi_counter.sv
// Shared period counter: 0..period wrap (edge) or 0..period..1 triangle (center).
module pwm_counter
  import ppwm_pkg::*;
#(
  parameter int CW = PWM_CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  pwm_mode_e     mode_i,
  input  logic [CW-1:0] period_i,
  output logic [CW-1:0] cnt_o,
  output logic          wrap_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          down_q, down_d;

  always_comb begin
    cnt_d  = cnt_q;
    down_d = down_q;
    if (!en_i) begin
      cnt_d  = '0;
      down_d = 1'b0;
    end else if (mode_i == PWM_EDGE) begin
      down_d = 1'b0;
      cnt_d  = (cnt_q >= period_i) ? '0 : cnt_q + CW'(1);
    end else if (down_q || (cnt_q >= period_i)) begin
      // Descending leg; turning back up happens as the count reaches 0.
      cnt_d  = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
      down_d = (cnt_q > CW'(1));
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      down_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      down_q <= down_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = (cnt_q == '0);

endmodule

// File: rtl/ppwm_multi.sv
// Multi-channel PWM: double-buffered mode/period/compare, applied at each period start.
module ppwm_multi
  import ppwm_pkg::*;
#(
  parameter int NUM_CH        = PWM_NUM_CH_DEF,
  parameter int COUNTER_WIDTH = PWM_CW_DEF
) (
  input  logic         clk,
  input  logic         rst,
  ppwm_multi_if.slave  ctl_if
);

  localparam int CW = COUNTER_WIDTH;

  pwm_mode_e           act_mode_q, sh_mode_q, eff_mode;
  logic [CW-1:0]       act_period_q, sh_period_q, eff_period;
  logic [CW-1:0]       act_cmp_q [NUM_CH];
  logic [CW-1:0]       sh_cmp_q  [NUM_CH];
  logic [CW-1:0]       eff_cmp   [NUM_CH];
  logic                pending_q, pending_d;
  logic [NUM_CH-1:0]   pwm_q, pwm_d, raw;
  logic                pstart_q, pstart_d;
  logic [CW-1:0]       cnt;
  logic                wrap;
  logic                apply;

  // The new set is bypassed in on the apply cycle so the whole period, cnt=0 included, uses it.
  assign apply = ctl_if.en_i && wrap && pending_q;

  always_comb begin
    eff_mode   = act_mode_q;
    eff_period = act_period_q;
    eff_cmp    = act_cmp_q;
    if (apply) begin
      eff_mode   = sh_mode_q;
      eff_period = sh_period_q;
      eff_cmp    = sh_cmp_q;
    end
  end

  pwm_counter #(.CW(CW)) u_counter (
    .clk      (clk),
    .rst      (rst),
    .en_i     (ctl_if.en_i),
    .mode_i   (eff_mode),
    .period_i (eff_period),
    .cnt_o    (cnt),
    .wrap_o   (wrap)
  );

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign raw[g] = (cnt < eff_cmp[g]);
  end

  always_comb begin
    pwm_d     = ctl_if.en_i ? (raw ^ ctl_if.pol_i) : ctl_if.pol_i;
    pstart_d  = ctl_if.en_i && wrap;
    pending_d = pending_q;
    if (ctl_if.upd_req_i) begin
      pending_d = 1'b1;
    end else if (apply) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_mode_q   <= PWM_EDGE;
      sh_mode_q    <= PWM_EDGE;
      act_period_q <= '0;
      sh_period_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        act_cmp_q[i] <= '0;
        sh_cmp_q[i]  <= '0;
      end
      pending_q <= 1'b0;
      pwm_q     <= '0;
      pstart_q  <= 1'b0;
    end else begin
      if (apply) begin
        act_mode_q   <= sh_mode_q;
        act_period_q <= sh_period_q;
        act_cmp_q    <= sh_cmp_q;
      end
      if (ctl_if.upd_req_i) begin
        sh_mode_q   <= pwm_mode_e'(ctl_if.mode_i);
        sh_period_q <= ctl_if.period_i;
        for (int i = 0; i < NUM_CH; i++) begin
          sh_cmp_q[i] <= ctl_if.cmp_i[i*CW +: CW];
        end
      end
      pending_q <= pending_d;
      pwm_q     <= pwm_d;
      pstart_q  <= pstart_d;
    end
  end

  assign ctl_if.pwm_o          = pwm_q;
  assign ctl_if.period_start_o = pstart_q;
  assign ctl_if.upd_pending_o  = pending_q;

endmodule

// File: tb/tb_ppwm_multi.sv
// Bench for ppwm_multi: directed scenarios plus random traffic against a phase-based model.
module tb_ppwm_multi;
  import ppwm_pkg::*;

  localparam int NCH = 4;
  localparam int CW  = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ppwm_multi_if #(.NUM_CH(NCH), .CW(CW)) bus ();

  ppwm_multi #(.NUM_CH(NCH), .COUNTER_WIDTH(CW)) dut (
    .clk    (clk),
    .rst    (rst),
    .ctl_if (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // stimulus configuration
  bit       s_mode;
  int       s_p;
  int       s_cmp [NCH];
  bit [3:0] s_pol;

  // model: position within the period plus active/shadow sets
  int       m_k;
  int       m_act_p, m_sh_p;
  bit       m_act_mode, m_sh_mode;
  int       m_act_cmp [NCH];
  int       m_sh_cmp  [NCH];
  bit       m_pend;
  bit [3:0] e_pwm;
  bit       e_ps;

  task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  function automatic int plen(input int p, input bit center);
    if (p == 0) return 1;
    return center ? 2 * p : p + 1;
  endfunction

  function automatic int pcnt(input int k, input int p);
    return (k <= p) ? k : 2 * p - k;
  endfunction

  task automatic model_reset();
    m_k = 0; m_act_p = 0; m_sh_p = 0; m_act_mode = 0; m_sh_mode = 0; m_pend = 0;
    for (int i = 0; i < NCH; i++) begin
      m_act_cmp[i] = 0;
      m_sh_cmp[i]  = 0;
    end
  endtask

  task automatic set_cfg(input bit mode, input int p, input int c0, input int c1,
                         input int c2, input int c3, input bit [3:0] pol);
    s_mode = mode; s_p = p; s_pol = pol;
    s_cmp[0] = c0; s_cmp[1] = c1; s_cmp[2] = c2; s_cmp[3] = c3;
  endtask

  // Entered just after a falling edge; returns just after the next falling edge.
  task automatic run_cycle(input bit en, input bit upd);
    int cnt;
    bus.en_i      = en;
    bus.mode_i    = s_mode;
    bus.period_i  = CW'(s_p);
    bus.pol_i     = s_pol;
    bus.upd_req_i = upd;
    for (int i = 0; i < NCH; i++) bus.cmp_i[i*CW +: CW] = CW'(s_cmp[i]);

    if (en && m_k == 0 && m_pend) begin
      m_act_p = m_sh_p; m_act_mode = m_sh_mode; m_act_cmp = m_sh_cmp; m_pend = 0;
    end
    cnt = en ? pcnt(m_k, m_act_p) : 0;
    for (int i = 0; i < NCH; i++)
      e_pwm[i] = en ? ((cnt < m_act_cmp[i]) ^ s_pol[i]) : s_pol[i];
    e_ps = en && (cnt == 0);
    m_k  = en ? (m_k + 1) % plen(m_act_p, m_act_mode) : 0;
    if (upd) begin
      m_sh_p = s_p; m_sh_mode = s_mode; m_sh_cmp = s_cmp; m_pend = 1;
    end

    @(posedge clk);
    #1;
    check_val("pwm_o", bus.pwm_o, e_pwm);
    check_val("period_start_o", bus.period_start_o, e_ps);
    check_val("upd_pending_o", bus.upd_pending_o, m_pend);
    @(negedge clk);
  endtask

  task automatic run_n(input int n, input bit en);
    for (int i = 0; i < n; i++) run_cycle(en, 1'b0);
  endtask

  task automatic mid_reset();
    #2 rst = 1'b1;
    #1;
    check_val("rst_pwm_o", bus.pwm_o, 0);
    check_val("rst_period_start_o", bus.period_start_o, 0);
    check_val("rst_upd_pending_o", bus.upd_pending_o, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic upd_on_apply();
    bit hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      if (m_k == 0 && m_pend) begin
        run_cycle(1'b1, 1'b1);
        hit = 1;
      end else begin
        run_cycle(1'b1, 1'b0);
      end
    end
    check_val("upd_on_apply_reached", hit, 1);
  endtask

  initial begin
    int len;
    rst = 1'b1;
    bus.en_i = 0; bus.mode_i = 0; bus.period_i = '0; bus.cmp_i = '0;
    bus.pol_i = '0; bus.upd_req_i = 0;
    set_cfg(0, 0, 0, 0, 0, 0, 4'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_val("reset_pwm_o", bus.pwm_o, 0);
    check_val("reset_period_start_o", bus.period_start_o, 0);
    check_val("reset_upd_pending_o", bus.upd_pending_o, 0);
    rst = 1'b0;

    // edge, period 9, 3/10 duty
    set_cfg(0, 9, 3, 5, 0, 10, 4'h0);
    run_cycle(1'b0, 1'b1);
    run_n(30, 1'b1);

    // center, period 4
    set_cfg(1, 4, 2, 4, 1, 5, 4'h0);
    run_cycle(1'b1, 1'b1);
    run_n(26, 1'b1);

    // cmp 0 and cmp>period with inversion
    set_cfg(0, 6, 0, 7, 6, 1023, 4'b1010);
    run_cycle(1'b1, 1'b1);
    run_n(20, 1'b1);

    // mid-period update of duty 3 -> 7
    set_cfg(0, 9, 3, 3, 3, 3, 4'h0);
    run_cycle(1'b1, 1'b1);
    run_n(14, 1'b1);
    set_cfg(0, 9, 7, 2, 9, 0, 4'h0);
    run_cycle(1'b1, 1'b1);
    run_n(25, 1'b1);

    // update request on the apply cycle
    set_cfg(1, 3, 1, 2, 3, 4, 4'h5);
    run_cycle(1'b1, 1'b1);
    set_cfg(0, 5, 4, 0, 6, 2, 4'h5);
    upd_on_apply();
    run_n(20, 1'b1);

    // period 0
    set_cfg(0, 0, 0, 1, 2, 0, 4'h8);
    run_cycle(1'b1, 1'b1);
    run_n(8, 1'b1);

    // disable mid-period with shadow load while idle, re-enable, then reset mid-run
    set_cfg(0, 9, 4, 8, 2, 6, 4'b0110);
    run_cycle(1'b1, 1'b1);
    run_n(15, 1'b1);
    run_n(3, 1'b0);
    set_cfg(1, 5, 3, 1, 6, 0, 4'b1001);
    run_cycle(1'b0, 1'b1);
    run_n(2, 1'b0);
    run_n(15, 1'b1);
    mid_reset();
    run_n(12, 1'b1);

    // random traffic
    for (int seg = 0; seg < 40; seg++) begin
      s_mode = 1'($urandom_range(0, 1));
      s_p    = $urandom_range(0, 12);
      for (int i = 0; i < NCH; i++)
        s_cmp[i] = ($urandom_range(0, 7) == 0) ? 1023 : $urandom_range(0, s_p + 2);
      s_pol = 4'($urandom_range(0, 15));
      len   = $urandom_range(5, 40);
      for (int i = 0; i < len; i++)
        run_cycle($urandom_range(0, 14) != 0, (i == 0) || ($urandom_range(0, 9) == 0));
      if (seg == 20) mid_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
